// File: rtl/trace_pkg.sv
// Shared constants and FSM state type for the signal trace writer and the VGA trace reader.
// Address constants must match the VGA controller's read-side map.
package trace_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int SAMPLE_W = 12;

  localparam logic [ADDR_W-1:0] ECG_BASE  = 12'h559;
  localparam logic [ADDR_W-1:0] EMG_BASE  = 12'h6AD;
  localparam logic [ADDR_W-1:0] STAT_BASE = 12'd1705;
  localparam int                TRACE_LEN = 320;

  typedef enum logic [2:0] {
    IDLE,
    WR_ECG,
    WR_EMG,
    ST0,
    ST1,
    ST2,
    ST3
  } trace_state_e;

endpackage

// File: rtl/signal_trace_writer_if.sv
// Sample-pair input handshake plus signal-memory write port of the trace writer.
// slave is the writer's view; master is the acquisition path / memory side.
interface signal_trace_writer_if
  import trace_pkg::*;
#(
  parameter int SAMPLE_W = trace_pkg::SAMPLE_W
) ();

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_ecg;
  logic [SAMPLE_W-1:0] s_emg;
  logic                mem_wEn;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data;

  modport master (
    output s_valid,
    output s_ecg,
    output s_emg,
    input  s_ready,
    input  mem_wEn,
    input  mem_addr,
    input  mem_data
  );

  modport slave (
    input  s_valid,
    input  s_ecg,
    input  s_emg,
    output s_ready,
    output mem_wEn,
    output mem_addr,
    output mem_data
  );

endinterface

// File: rtl/trace_minmax.sv
// Running min/max tracker for one channel over a sweep.
// Outputs are range-guarded so the display divider never sees max == min.
module trace_minmax #(
  parameter int SAMPLE_W = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                update,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] min_val,
  output logic [SAMPLE_W-1:0] max_val
);

  logic [SAMPLE_W-1:0] min_q;
  logic [SAMPLE_W-1:0] max_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (update) begin
      if (sample < min_q) min_q <= sample;
      if (sample > max_q) max_q <= sample;
    end
  end

  // A flat sweep is widened by one code; at full scale the min moves down instead.
  always_comb begin
    min_val = min_q;
    max_val = max_q;
    if (min_q == max_q) begin
      if (&min_q) min_val = min_q - 1'b1;
      else        max_val = max_q + 1'b1;
    end
  end

endmodule

// File: rtl/signal_trace_writer.sv
// Decimates ECG/EMG sample pairs into one TRACE_LEN-point sweep per channel in signal memory,
// followed by the per-channel min/max words used for vertical scaling.
//
// state  | meaning (state names the write currently on the memory port)
// IDLE   | accepting pairs, no write
// WR_ECG | ECG_BASE+idx being written
// WR_EMG | EMG_BASE+idx being written
// ST0    | STAT_BASE+0 <- min_ecg
// ST1    | STAT_BASE+1 <- min_emg
// ST2    | STAT_BASE+2 <- max_ecg
// ST3    | STAT_BASE+3 <- max_emg, sweep_done pulse, trackers reload on exit
module signal_trace_writer
  import trace_pkg::*;
#(
  parameter logic [11:0] ECG_BASE  = trace_pkg::ECG_BASE,
  parameter logic [11:0] EMG_BASE  = trace_pkg::EMG_BASE,
  parameter logic [11:0] STAT_BASE = trace_pkg::STAT_BASE,
  parameter int          TRACE_LEN = trace_pkg::TRACE_LEN,
  parameter int          DECIM     = 4,
  parameter int          SAMPLE_W  = trace_pkg::SAMPLE_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  freeze,
  signal_trace_writer_if.slave  bus,
  output logic                  sweep_done
);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int IDX_W  = $clog2(TRACE_LEN);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TRACE_LEN - 1);

  trace_state_e        state;
  logic [DCNT_W-1:0]   dcnt;
  logic [IDX_W-1:0]    idx;
  logic [SAMPLE_W-1:0] emg_q;

  logic                xfer;
  logic                keep;
  logic                stat_clear;
  logic [SAMPLE_W-1:0] ecg_min, ecg_max, emg_min, emg_max;

  assign xfer       = bus.s_valid && bus.s_ready;
  assign keep       = xfer && (dcnt == DCNT_LAST);
  assign stat_clear = (state == ST3);

  function automatic logic [DATA_W-1:0] zext(input logic [SAMPLE_W-1:0] v);
    return DATA_W'(v);
  endfunction

  trace_minmax #(.SAMPLE_W(SAMPLE_W)) u_ecg_minmax (
    .clock   (clock),
    .reset   (reset),
    .clear   (stat_clear),
    .update  (keep),
    .sample  (bus.s_ecg),
    .min_val (ecg_min),
    .max_val (ecg_max)
  );

  trace_minmax #(.SAMPLE_W(SAMPLE_W)) u_emg_minmax (
    .clock   (clock),
    .reset   (reset),
    .clear   (stat_clear),
    .update  (keep),
    .sample  (bus.s_emg),
    .min_val (emg_min),
    .max_val (emg_max)
  );

  // Outputs are loaded on the edge that enters a state, so each write is visible
  // for exactly the cycle the FSM spends in that state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      dcnt         <= '0;
      idx          <= '0;
      emg_q        <= '0;
      bus.s_ready  <= 1'b0;
      bus.mem_wEn  <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      sweep_done   <= 1'b0;
    end else begin
      bus.mem_wEn <= 1'b0;
      bus.s_ready <= 1'b0;
      sweep_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (keep) begin
            dcnt         <= '0;
            emg_q        <= bus.s_emg;
            state        <= WR_ECG;
            bus.mem_wEn  <= 1'b1;
            bus.mem_addr <= ECG_BASE + 12'(idx);
            bus.mem_data <= zext(bus.s_ecg);
          end else begin
            if (xfer) dcnt <= dcnt + 1'b1;
            bus.s_ready <= !freeze;
          end
        end
        WR_ECG: begin
          state        <= WR_EMG;
          bus.mem_wEn  <= 1'b1;
          bus.mem_addr <= EMG_BASE + 12'(idx);
          bus.mem_data <= zext(emg_q);
        end
        WR_EMG: begin
          if (idx == IDX_LAST) begin
            idx          <= '0;
            state        <= ST0;
            bus.mem_wEn  <= 1'b1;
            bus.mem_addr <= STAT_BASE;
            bus.mem_data <= zext(ecg_min);
          end else begin
            idx         <= idx + 1'b1;
            state       <= IDLE;
            bus.s_ready <= !freeze;
          end
        end
        ST0: begin
          state        <= ST1;
          bus.mem_wEn  <= 1'b1;
          bus.mem_addr <= STAT_BASE + 12'd1;
          bus.mem_data <= zext(emg_min);
        end
        ST1: begin
          state        <= ST2;
          bus.mem_wEn  <= 1'b1;
          bus.mem_addr <= STAT_BASE + 12'd2;
          bus.mem_data <= zext(ecg_max);
        end
        ST2: begin
          state        <= ST3;
          bus.mem_wEn  <= 1'b1;
          bus.mem_addr <= STAT_BASE + 12'd3;
          bus.mem_data <= zext(emg_max);
          sweep_done   <= 1'b1;
        end
        ST3: begin
          state       <= IDLE;
          bus.s_ready <= !freeze;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_trace_writer.sv
// Randomised bench for signal_trace_writer: transfers seen on the handshake feed a
// sweep-level reference model whose expected memory writes are compared in order.
module tb_signal_trace_writer;
  import trace_pkg::*;

  localparam int DECIM_TB = 4;
  localparam int SW       = 12;

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic freeze = 1'b0;
  logic sweep_done;

  signal_trace_writer_if #(.SAMPLE_W(SW)) bus ();

  signal_trace_writer #(.DECIM(DECIM_TB), .SAMPLE_W(SW)) dut (
    .clock      (clock),
    .reset      (reset),
    .freeze     (freeze),
    .bus        (bus),
    .sweep_done (sweep_done)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  wr_t         exp_q[$];
  int          sw_ecg[$];
  int          sw_emg[$];
  int          acc_cnt   = 0;
  int          m_idx     = 0;
  int          busy_left = 0;
  logic        edge_freeze = 1'b0;
  logic        edge_rst    = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          trace_wr = 0;
  int          done_cnt = 0;
  logic [11:0] last_ecg_addr = '0;
  logic [11:0] last_emg_addr = '0;
  logic [11:0] done_addr     = '0;
  int          obs_stat[4];
  bit          st1_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    sw_ecg.delete();
    sw_emg.delete();
    acc_cnt   = 0;
    m_idx     = 0;
    busy_left = 0;
  endtask

  // Range of one channel over the sweep, widened to a nonzero span for the display.
  task automatic sweep_range(input int q[$], output int mn, output int mx);
    mn = 4095;
    mx = 0;
    foreach (q[i]) begin
      if (q[i] < mn) mn = q[i];
      if (q[i] > mx) mx = q[i];
    end
    if (mn == mx) begin
      if (mn == 4095) mn = 4094;
      else            mx = mn + 1;
    end
  endtask

  task automatic model_accept(input int ecg, input int emg);
    int mn_e, mx_e, mn_m, mx_m;
    acc_cnt++;
    if (acc_cnt % DECIM_TB != 0) return;
    exp_q.push_back('{12'(int'(ECG_BASE) + m_idx), 32'(ecg), 1'b0});
    exp_q.push_back('{12'(int'(EMG_BASE) + m_idx), 32'(emg), 1'b0});
    sw_ecg.push_back(ecg);
    sw_emg.push_back(emg);
    m_idx++;
    if (m_idx == TRACE_LEN) begin
      sweep_range(sw_ecg, mn_e, mx_e);
      sweep_range(sw_emg, mn_m, mx_m);
      exp_q.push_back('{STAT_BASE,         32'(mn_e), 1'b0});
      exp_q.push_back('{STAT_BASE + 12'd1, 32'(mn_m), 1'b0});
      exp_q.push_back('{STAT_BASE + 12'd2, 32'(mx_e), 1'b0});
      exp_q.push_back('{STAT_BASE + 12'd3, 32'(mx_m), 1'b1});
      sw_ecg.delete();
      sw_emg.delete();
      m_idx     = 0;
      busy_left = 6;
    end else begin
      busy_left = 2;
    end
  endtask

  task automatic post_check();
    wr_t w;
    int  a;
    if (!reset) begin
      check_eq("rst_ready", 32'(bus.s_ready), 0);
      check_eq("rst_wen",   32'(bus.mem_wEn), 0);
      check_eq("rst_addr",  32'(bus.mem_addr), 0);
      check_eq("rst_data",  bus.mem_data, 0);
      check_eq("rst_done",  32'(sweep_done), 0);
      model_clear();
      return;
    end
    if (!edge_rst) begin
      check_eq("ready_in_rst", 32'(bus.s_ready), 0);
    end else if (busy_left > 0) begin
      check_eq("ready_busy", 32'(bus.s_ready), 0);
      busy_left--;
    end else begin
      check_eq("ready_idle", 32'(bus.s_ready), 32'(!edge_freeze));
    end
    if (sweep_done) begin
      done_cnt++;
      done_addr = bus.mem_addr;
    end
    if (bus.mem_wEn) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_wr", 32'(bus.mem_wEn), 0);
      end else begin
        w = exp_q.pop_front();
        check_eq("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
        check_eq("wr_data", bus.mem_data, w.data);
        check_eq("wr_done", 32'(sweep_done), 32'(w.done));
      end
      a = int'(bus.mem_addr);
      if (a >= int'(STAT_BASE) && a < int'(STAT_BASE) + 4) obs_stat[a - int'(STAT_BASE)] = int'(bus.mem_data);
      if (a == int'(STAT_BASE) + 1) st1_seen = 1'b1;
      if (a >= int'(ECG_BASE) && a < int'(ECG_BASE) + TRACE_LEN) begin
        last_ecg_addr = bus.mem_addr;
        trace_wr++;
      end
      if (a >= int'(EMG_BASE) && a < int'(EMG_BASE) + TRACE_LEN) begin
        last_emg_addr = bus.mem_addr;
        trace_wr++;
      end
    end else begin
      check_eq("done_idle", 32'(sweep_done), 0);
    end
  endtask

  // Inputs for the coming edge are already driven; sample outputs on the falling edge.
  task automatic tick();
    if (reset && bus.s_valid && bus.s_ready) model_accept(int'(bus.s_ecg), int'(bus.s_emg));
    edge_freeze = freeze;
    edge_rst    = reset;
    @(posedge clock);
    @(negedge clock);
    post_check();
  endtask

  task automatic send(input int ecg, input int emg);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_ecg   = SW'(ecg);
    bus.s_emg   = SW'(emg);
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = bus.s_ready && reset;
      tick();
    end
    check_eq("accepted", 32'(ok), 1);
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int pairs;
    bus.s_valid = 1'b0;
    bus.s_ecg   = '0;
    bus.s_emg   = '0;

    // reset state and first ready
    repeat (3) tick();
    reset = 1'b1;
    idle(2);

    // decimation: 8 back-to-back pairs keep k=3 and k=7
    for (int k = 0; k < 8; k++) send(100 + k, 200 + k);
    idle(4);
    check_eq("decim_trace_writes", 32'(trace_wr), 4);
    check_eq("decim_last_ecg", 32'(last_ecg_addr), 32'h55A);
    check_eq("decim_last_emg", 32'(last_emg_addr), 32'h6AE);

    // freeze raised while the ECG write is on the port
    for (int k = 0; k < 3; k++) send($urandom_range(0, 4095), $urandom_range(0, 4095));
    send(900, 901);
    freeze = 1'b1;
    bus.s_ecg = SW'($urandom_range(0, 4095));
    repeat (6) tick();
    check_eq("freeze_emg_written", 32'(last_emg_addr), 32'(EMG_BASE + 12'd2));
    check_eq("freeze_trace_writes", 32'(trace_wr), 6);
    freeze = 1'b0;
    for (int k = 0; k < 4; k++) send($urandom_range(0, 4095), $urandom_range(0, 4095));
    idle(3);
    check_eq("freeze_next_idx", 32'(last_ecg_addr), 32'(ECG_BASE + 12'd3));

    // rest of this sweep with random data and random valid gaps
    pairs = (TRACE_LEN - m_idx) * DECIM_TB;
    for (int k = 0; k < pairs; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send($urandom_range(0, 4095), $urandom_range(0, 4095));
    end
    idle(10);
    check_eq("bp_sweep_done", 32'(done_cnt), 1);

    // full ramp sweep
    for (int k = 0; k < TRACE_LEN * DECIM_TB; k++) send(10 + k / DECIM_TB, 500);
    idle(10);
    check_eq("ramp_last_ecg", 32'(last_ecg_addr), 32'h698);
    check_eq("ramp_last_emg", 32'(last_emg_addr), 32'h7EC);
    check_eq("ramp_min_ecg", 32'(obs_stat[0]), 10);
    check_eq("ramp_min_emg", 32'(obs_stat[1]), 500);
    check_eq("ramp_max_ecg", 32'(obs_stat[2]), 329);
    check_eq("ramp_max_emg", 32'(obs_stat[3]), 501);
    check_eq("ramp_done_cnt", 32'(done_cnt), 2);
    check_eq("ramp_done_addr", 32'(done_addr), 1708);
    for (int k = 0; k < DECIM_TB; k++) send($urandom_range(0, 4095), $urandom_range(0, 4095));
    idle(3);
    check_eq("wrap_first_ecg", 32'(last_ecg_addr), 32'h559);

    // reset during ST1
    pairs = (TRACE_LEN - m_idx) * DECIM_TB;
    for (int k = 0; k < pairs; k++) send($urandom_range(0, 4095), $urandom_range(0, 4095));
    st1_seen = 1'b0;
    bus.s_valid = 1'b0;
    for (int i = 0; i < 20 && !st1_seen; i++) tick();
    check_eq("st1_reached", 32'(st1_seen), 1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_ready", 32'(bus.s_ready), 0);
    check_eq("async_wen",   32'(bus.mem_wEn), 0);
    check_eq("async_addr",  32'(bus.mem_addr), 0);
    check_eq("async_data",  bus.mem_data, 0);
    check_eq("async_done",  32'(sweep_done), 0);
    done_cnt = 0;
    repeat (3) tick();
    reset = 1'b1;
    idle(3);
    check_eq("no_done_after_rst", 32'(done_cnt), 0);

    // saturated sweep, also the first sweep after reset
    for (int k = 0; k < TRACE_LEN * DECIM_TB; k++) begin
      send(4095, 4095);
      if (k == DECIM_TB - 1) begin
        idle(2);
        check_eq("first_after_rst", 32'(last_ecg_addr), 32'(ECG_BASE));
      end
    end
    idle(10);
    check_eq("sat_min_ecg", 32'(obs_stat[0]), 4094);
    check_eq("sat_min_emg", 32'(obs_stat[1]), 4094);
    check_eq("sat_max_ecg", 32'(obs_stat[2]), 4095);
    check_eq("sat_max_emg", 32'(obs_stat[3]), 4095);
    check_eq("sat_done_cnt", 32'(done_cnt), 1);
    check_eq("pending_writes", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_trace_writer.md
# signal_trace_writer

Upstream feeder for the VGA trace display. Accepts paired ECG/EMG samples from the acquisition path and decimates them. It writes one 320-point sweep per channel into the shared signal memory that the VGA controller reads through its `sig_addr`/`sig_data` port. At the end of each sweep it writes the per-channel min/max words the display uses for vertical scaling.

## Interface
Parameters:
- `ECG_BASE`, 12'h559: first ECG trace word.
- `EMG_BASE`, 12'h6AD: first EMG trace word.
- `STAT_BASE`, 12'd1705: min_ecg, min_emg, max_ecg, max_emg at +0..+3.
- `TRACE_LEN`, 320: points per sweep.
- `DECIM`, 4: keep one of every DECIM accepted pairs; must be ≥1.
- `SAMPLE_W`, 12: sample width.

Ports:
- `clock` in 1: system clock. One clock only; the memory write port is on this clock.
- `reset` in 1: asynchronous, active-low.
- `s_valid` in 1: sample pair valid.
- `s_ready` out 1: block can accept a pair.
- `s_ecg` in SAMPLE_W: ECG sample, unsigned.
- `s_emg` in SAMPLE_W: EMG sample, unsigned.
- `freeze` in 1: hold display. No new pairs accepted while high.
- `mem_wEn` out 1: write strobe to signal memory.
- `mem_addr` out 12: write address.
- `mem_data` out 32: write data, sample zero-extended.
- `sweep_done` out 1: one-cycle pulse at the end of each sweep.

## Operation
- **Handshake.** A pair transfers when `s_valid && s_ready`. `s_ready = (state==IDLE) && !freeze`, registered.
- **Decimation.** `dcnt` counts 0..DECIM-1 on every transfer. Only a transfer with `dcnt==DECIM-1` is kept; it latches `s_ecg`/`s_emg`. Other transfers are dropped and consume one IDLE cycle.
- **States.**
  - IDLE: on a kept transfer, go to WR_ECG.
  - WR_ECG: write `ECG_BASE+idx`, then WR_EMG.
  - WR_EMG: write `EMG_BASE+idx`.
    - If `idx==TRACE_LEN-1`: go to ST0, set `idx` to 0.
    - Otherwise: `idx++`, go to IDLE.
  - ST0..ST3: write `STAT_BASE+0..3` with min_ecg, min_emg, max_ecg, max_emg, then go to IDLE.
- **Min/max.**
  - Running min/max per channel, updated on each kept sample, including the last sample of the sweep.
  - After ST3, trackers reload to min=4095, max=0.
  - In a sweep of constant data, max is written as min+1. If min is 4095, min is written as 4094 and max as 4095. This keeps the range nonzero for the display divider.
- **Address arithmetic.** `base+idx` is 12-bit. Parameters are chosen so no wrap occurs: 0x559+319 < 0x6A9 and 0x6AD+319 < 0x1000.
- **freeze.** Takes effect only in IDLE. A write sequence already started, including the ST sequence, always completes. `idx` and `dcnt` hold while frozen.
- **Reset.** Takes effect at any time, including mid-sequence. The sequence is abandoned: state IDLE, idx 0, dcnt 0, trackers reloaded. Partially written sweeps are not repaired.

## Timing
- All outputs are registered.
- Reset values: `s_ready` 0, `mem_wEn` 0, `mem_addr` 0, `mem_data` 0, `sweep_done` 0. `s_ready` rises on the first clock after reset deasserts, if `freeze` is low.
- Kept transfer at cycle N:
  - ECG write visible at N+1 (`mem_wEn`=1).
  - EMG write at N+2.
  - `s_ready` high again at N+3.
- Throughput: one kept pair per 3 cycles. A dropped pair can be accepted every cycle in IDLE.
- End of sweep: the ST writes occur at N+3..N+6. `sweep_done` pulses in the N+6 cycle, coinciding with the ST3 write. `s_ready` returns at N+7.
- `mem_wEn` is low in IDLE. `mem_addr`/`mem_data` hold their last values when not writing.
- Memory write has no backpressure: signal memory accepts a write every cycle. The VGA read port is independent (dual-port RAM).

## Structure
- Package `trace_pkg`:
  - Address constants ECG_BASE, EMG_BASE, STAT_BASE, TRACE_LEN, shared with the VGA controller.
  - State enum: IDLE, WR_ECG, WR_EMG, ST0, ST1, ST2, ST3.
- Sub-module `trace_minmax`, one per channel:
  - Ports: clear, update, sample; outputs min and max, with range-guard outputs.
  - The top holds the FSM, `dcnt`, `idx`, and the output registers.

## Test plan
- **Decimation.** DECIM=4, 8 back-to-back pairs, ecg=100+k, emg=200+k, k=0..7. Required: exactly 2 ECG/EMG write pairs, at 0x559/0x6AD data 103/203 and at 0x55A/0x6AE data 107/207. `s_ready` low for 2 cycles after each kept pair.
- **Full sweep.** DECIM=1, 320 pairs, ecg ramp 10..329, emg constant 500. Required:
  - Writes end at 0x698/0x7EC.
  - Then 1705=10, 1706=500, 1707=329, 1708=501.
  - `sweep_done` for one cycle, coincident with the 1708 write.
  - Next pair writes 0x559.
- **Saturation guard.** A sweep of all 4095. Required: min word 4094, max word 4095.
- **Freeze.** Assert `freeze` during WR_ECG. Required: WR_EMG still writes, `s_ready` stays 0 while frozen, and on release the next kept pair writes the next idx.
- **Reset mid-sweep.** Pull `reset` low during ST1. Required:
  - Outputs go 0 immediately (async).
  - After release, the first kept pair writes 0x559.
  - No `sweep_done` pulse.
- **Backpressure.** Random `s_valid` gaps. Required: no pair is accepted while `s_ready`=0, and no kept sample is lost or duplicated, checked against a scoreboard.
